// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT control slice: the stage-sequencer FSM
// encoding, the legal transform sizes and small helpers that map a size to
// its stage count. Used by the stage sequencer, the angle generator and the
// butterfly datapath, so all three agree on what a "legal size" is.
// ---------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [4:0] SZ2  = 5'd2;
    localparam logic [4:0] SZ4  = 5'd4;
    localparam logic [4:0] SZ8  = 5'd8;
    localparam logic [4:0] SZ16 = 5'd16;

    function automatic logic size_legal(input logic [4:0] size);
        return (size == SZ2) || (size == SZ4) || (size == SZ8) || (size == SZ16);
    endfunction

    // log2 of a legal size; 0 for anything illegal
    function automatic logic [2:0] size_log2(input logic [4:0] size);
        case (size)
            SZ2:     return 3'd1;
            SZ4:     return 3'd2;
            SZ8:     return 3'd3;
            SZ16:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // index of the final stage: log2(size) - 1
    function automatic logic [1:0] last_stage(input logic [4:0] size);
        case (size)
            SZ2:     return 2'd0;
            SZ4:     return 2'd1;
            SZ8:     return 2'd2;
            SZ16:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
// Stage-control side of the twiddle/angle interface. A start request in IDLE
// latches transform size and direction, then the block steps through stages
// 0..log2(size)-1, holding e_start high while stages run. Each stage advances
// on a one-cycle acknowledge from the butterfly datapath. The twiddle-LUT
// stride for the current stage, (N/number) << stage, is produced alongside.
//
// Optional feature (macro STAGE_TIMEOUT_EN): per-stage watchdog. When defined,
// a stage that sees no stage_ack for TIMEOUT cycles raises err and returns the
// sequencer to IDLE without a done pulse. When undefined, RUN waits forever.
//
// Parameters
//   N          max FFT points (legal sizes 2..N, powers of two)
//   TIMEOUT    per-stage watchdog limit in cycles (watchdog builds only)
// Ports
//   clk        clock, all logic on rising edge
//   rst        synchronous active-high reset
//   start      request a new transform; only looked at in IDLE
//   fft_size   requested points: 2, 4, 8 or 16
//   inverse_i  1 = inverse transform, latched with start
//   stage_ack  one-cycle pulse: datapath finished the current stage
//   number     latched size, to the angle generator
//   stage      current stage index
//   e_start    stage enable to angle generator / butterflies
//   inverse    latched direction
//   tw_stride  twiddle LUT index stride for the current stage
//   busy       high from accept until the final stage is acknowledged
//   done       one-cycle pulse after the final stage acknowledge
//   err        sticky: illegal size or watchdog expiry; cleared on accept
// ---------------------------------------------------------------------------
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int N       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] fft_size,
    input  logic       inverse_i,
    input  logic       stage_ack,
    output logic [4:0] number,
    output logic [1:0] stage,
    output logic       e_start,
    output logic       inverse,
    output logic [3:0] tw_stride,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     state;
    state_t     state_next;
    logic       size_ok;
    logic       accept;
    logic       at_last;
    logic [3:0] stride_base;
    logic       timeout_hit;

    // sizes above N have no twiddles in the LUT, so treat them as illegal too
    assign size_ok     = size_legal(fft_size) && (int'(fft_size) <= N);
    assign accept      = (state == IDLE) && start && size_ok;
    assign at_last     = (stage == last_stage(number));
    assign stride_base = 4'(N >> size_log2(fft_size));

`ifdef STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;

    // Counts RUN cycles since entry or the last ack; it sits at zero outside
    // RUN, so entering RUN always starts a fresh window.
    always_ff @(posedge clk) begin
        if (rst || (state != RUN) || stage_ack)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + CNT_W'(1);
    end

    // an ack in the expiry cycle still counts as on time
    assign timeout_hit = (state == RUN) && !stage_ack &&
                         (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN: begin
                if (stage_ack && at_last)
                    state_next = FIN;
                else if (timeout_hit)
                    state_next = IDLE;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // outputs decoded from the registered state, so they change exactly one
    // cycle after the event that moved the FSM
    always_comb begin
        e_start = (state == RUN);
        busy    = (state == RUN);
        done    = (state == FIN);
    end

    // latched transform parameters, stage index, stride and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            number    <= '0;
            inverse   <= 1'b0;
            stage     <= '0;
            tw_stride <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            number    <= fft_size;
                            inverse   <= inverse_i;
                            stage     <= '0;
                            tw_stride <= stride_base;
                            err       <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // on the final ack stage holds its last value through FIN
                    if (stage_ack && !at_last) begin
                        stage     <= stage + 2'd1;
                        tw_stride <= tw_stride << 1;
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
module tb_fft_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] fft_size;
    logic       inverse_i;
    logic       stage_ack;
    logic [4:0] number;
    logic [1:0] stage;
    logic       e_start;
    logic       inverse;
    logic [3:0] tw_stride;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: what the sequencer should be holding
    int m_number  = 0;
    bit m_inverse = 0;
    int m_stage   = 0;
    int m_stride  = 0;
    bit m_err     = 0;

    always #5 clk = ~clk;

    fft_stage_sequencer #(.N(16), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fft_size  (fft_size),
        .inverse_i (inverse_i),
        .stage_ack (stage_ack),
        .number    (number),
        .stage     (stage),
        .e_start   (e_start),
        .inverse   (inverse),
        .tw_stride (tw_stride),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // number of radix-2 stages for s points
    function automatic int ref_stages(input int s);
        int n = 0;
        int p = 1;
        while (p < s) begin
            p = p * 2;
            n++;
        end
        return n;
    endfunction

    // LUT holds 16/2 twiddles; stage k of an s-point transform strides by (16/s)*2^k
    function automatic int ref_stride(input int s, input int k);
        return (16 / s) * (2 ** k);
    endfunction

    function automatic bit ref_legal(input int s);
        return (s == 2) || (s == 4) || (s == 8) || (s == 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stage_ack = 1'b0; fft_size = 5'd0; inverse_i = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({number, stage, e_start, inverse, tw_stride, busy, done, err} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0000",
                     {number, stage, e_start, inverse, tw_stride, busy, done, err});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({number, stage, e_start, inverse, tw_stride, busy, done, err} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_release: got %h want 0000",
                     {number, stage, e_start, inverse, tw_stride, busy, done, err});
        end
        m_number = 0; m_inverse = 0; m_stage = 0; m_stride = 0; m_err = 0;
    endtask

    // One complete transform, checked cycle by cycle. mid_start >= 0 pulses a
    // conflicting start while that stage is running; max_gap inserts idle
    // cycles before each ack.
    task automatic test_transform(input int s, input bit inv, input int mid_start, input int max_gap);
        int last;
        int gap;
        last = ref_stages(s) - 1;
        start = 1'b1; fft_size = 5'(s); inverse_i = inv;
        tick();
        start = 1'b0; fft_size = 5'($urandom); inverse_i = 1'($urandom);
        m_number = s; m_inverse = inv; m_err = 0;
        for (int k = 0; k <= last; k++) begin
            if (k == mid_start) begin
                start = 1'b1; fft_size = 5'd4; inverse_i = !inv;
                tick();
                start = 1'b0;
            end
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) tick();
            m_stage = k; m_stride = ref_stride(s, k);
            n_cmp++;
            if ({number, inverse, stage, tw_stride} !== {5'(m_number), m_inverse, 2'(m_stage), 4'(m_stride)}) begin
                n_bad++;
                $display("FAIL stage_state s=%0d k=%0d: got num=%0d inv=%0d stg=%0d str=%0d want num=%0d inv=%0d stg=%0d str=%0d",
                         s, k, number, inverse, stage, tw_stride, m_number, m_inverse, m_stage, m_stride);
            end
            n_cmp++;
            if ({e_start, busy, done, err} !== 4'b1100) begin
                n_bad++;
                $display("FAIL stage_ctl s=%0d k=%0d: got e/b/d/err=%b want 1100", s, k, {e_start, busy, done, err});
            end
            stage_ack = 1'b1;
            tick();
            stage_ack = 1'b0;
        end
        // FIN cycle; a start here must be ignored
        n_cmp++;
        if ({e_start, busy, done, stage} !== {3'b001, 2'(last)}) begin
            n_bad++;
            $display("FAIL fin s=%0d: got e/b/d=%b stg=%0d want 001 stg=%0d", s, {e_start, busy, done}, stage, last);
        end
        start = 1'($urandom); fft_size = 5'd16; inverse_i = !inv;
        tick();
        start = 1'b0;
        // IDLE: done gone, values held; a stray ack must not move anything
        stage_ack = 1'b1;
        tick();
        stage_ack = 1'b0;
        n_cmp++;
        if ({e_start, busy, done, err, number, inverse, stage, tw_stride} !==
            {4'b0000, 5'(m_number), m_inverse, 2'(m_stage), 4'(m_stride)}) begin
            n_bad++;
            $display("FAIL idle_hold s=%0d: got e/b/d/err=%b num=%0d inv=%0d stg=%0d str=%0d want 0000 num=%0d inv=%0d stg=%0d str=%0d",
                     s, {e_start, busy, done, err}, number, inverse, stage, tw_stride, m_number, m_inverse, m_stage, m_stride);
        end
    endtask

    task automatic test_size16_fwd();
        test_transform(16, 1'b0, -1, 0);
    endtask

    task automatic test_size2_inverse();
        test_transform(2, 1'b1, -1, 0);
    endtask

    task automatic test_illegal_size();
        start = 1'b1; fft_size = 5'd6; inverse_i = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({err, busy, e_start, done, number, inverse} !== {4'b1000, 5'(m_number), m_inverse}) begin
            n_bad++;
            $display("FAIL illegal_6: got err/b/e/d=%b num=%0d inv=%0d want 1000 num=%0d inv=%0d",
                     {err, busy, e_start, done}, number, inverse, m_number, m_inverse);
        end
        tick();
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        test_transform(8, 1'b0, -1, 1);
    endtask

    task automatic test_start_mid_run();
        test_transform(16, 1'b0, 2, 1);
    endtask

    task automatic test_rst_mid();
        start = 1'b1; fft_size = 5'd16; inverse_i = 1'b1;
        tick();
        start = 1'b0;
        stage_ack = 1'b1;
        tick();
        stage_ack = 1'b0;
        n_cmp++;
        if ({stage, busy} !== 3'b011) begin
            n_bad++;
            $display("FAIL pre_rst: got stg=%0d busy=%b want stg=1 busy=1", stage, busy);
        end
        rst = 1'b1; stage_ack = 1'b1;
        tick();
        rst = 1'b0; stage_ack = 1'b0;
        n_cmp++;
        if ({number, stage, e_start, inverse, tw_stride, busy, done, err} !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_mid: got %h want 0000",
                     {number, stage, e_start, inverse, tw_stride, busy, done, err});
        end
        tick();
        n_cmp++;
        if ({number, stage, e_start, inverse, tw_stride, busy, done, err} !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_after: got %h want 0000",
                     {number, stage, e_start, inverse, tw_stride, busy, done, err});
        end
        m_number = 0; m_inverse = 0; m_stage = 0; m_stride = 0; m_err = 0;
    endtask

    task automatic test_timeout();
        start = 1'b1; fft_size = 5'd8; inverse_i = 1'b0;
        tick();
        start = 1'b0;
        m_number = 8; m_inverse = 0; m_stage = 0; m_stride = ref_stride(8, 0);
`ifdef STAGE_TIMEOUT_EN
        repeat (63) tick();
        n_cmp++;
        if ({e_start, busy, err} !== 3'b110) begin
            n_bad++;
            $display("FAIL wd_before: got e/b/err=%b want 110", {e_start, busy, err});
        end
        tick();
        n_cmp++;
        if ({e_start, busy, done, err} !== 4'b0001) begin
            n_bad++;
            $display("FAIL wd_expire: got e/b/d/err=%b want 0001", {e_start, busy, done, err});
        end
        tick();
        n_cmp++;
        if ({e_start, busy, done, err, number, stage} !== {4'b0001, 5'd8, 2'd0}) begin
            n_bad++;
            $display("FAIL wd_after: got e/b/d/err=%b num=%0d stg=%0d want 0001 num=8 stg=0",
                     {e_start, busy, done, err}, number, stage);
        end
`else
        repeat (100) tick();
        n_cmp++;
        if ({e_start, busy, done, err, stage} !== {4'b1100, 2'd0}) begin
            n_bad++;
            $display("FAIL no_wd_wait: got e/b/d/err=%b stg=%0d want 1100 stg=0", {e_start, busy, done, err}, stage);
        end
        for (int k = 0; k < 3; k++) begin
            stage_ack = 1'b1;
            tick();
            stage_ack = 1'b0;
        end
        n_cmp++;
        if ({done, stage} !== {1'b1, 2'd2}) begin
            n_bad++;
            $display("FAIL no_wd_done: got d=%b stg=%0d want d=1 stg=2", done, stage);
        end
        tick();
`endif
    endtask

    task automatic test_random();
        int s;
        int v;
        int mid;
        repeat (25) begin
            if ($urandom_range(0, 5) == 0) begin
                v = $urandom_range(0, 31);
                while (ref_legal(v)) v = $urandom_range(0, 31);
                start = 1'b1; fft_size = 5'(v); inverse_i = 1'($urandom);
                tick();
                start = 1'b0;
                m_err = 1;
                n_cmp++;
                if ({err, busy, number} !== {1'b1, 1'b0, 5'(m_number)}) begin
                    n_bad++;
                    $display("FAIL rand_illegal v=%0d: got err=%b busy=%b num=%0d want err=1 busy=0 num=%0d",
                             v, err, busy, number, m_number);
                end
            end else begin
                s = 1 << $urandom_range(1, 4);
                mid = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ref_stages(s) - 1) : -1;
                test_transform(s, 1'($urandom), mid, 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_size16_fwd();
        test_size2_inverse();
        test_illegal_size();
        test_start_mid_run();
        test_rst_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
